// File: rtl/osd_stream_reader.sv
// Pulls pixels from an upstream FIFO with RD_LAT read latency into a RD_LAT+1 deep
// buffer and presents them as a valid/ready stream framed by sop/eop markers.
module osd_stream_reader #(
   parameter int DATA_W   = 24,
   parameter int RD_LAT   = 1,
   parameter int H_ACTIVE = 1920,
   parameter int V_ACTIVE = 1080
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              fifo_empty_i,
   input  logic [DATA_W-1:0] fifo_q_i,
   output logic              fifo_rdreq_o,
   output logic              fifo_aclr_o,
   input  logic              vst_ready_i,
   output logic              vst_valid_o,
   output logic [DATA_W-1:0] vst_data_o,
   output logic              vst_sop_o,
   output logic              vst_eop_o,
   output logic              frame_done_o
);

   localparam int BUF_D = RD_LAT + 1;
   localparam int PTR_W = (BUF_D > 1) ? $clog2(BUF_D) : 1;
   localparam int CNT_W = $clog2(BUF_D + 1);
   localparam int H_W   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam int V_W   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_D - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUF_D);
   localparam logic [H_W-1:0]   H_LAST   = H_W'(H_ACTIVE - 1);
   localparam logic [V_W-1:0]   V_LAST   = V_W'(V_ACTIVE - 1);

   logic [DATA_W-1:0] buf_q [BUF_D];
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  occ_q, occ_d;
   logic [CNT_W-1:0]  in_flight;
   logic [RD_LAT-1:0] pipe_q, pipe_d;
   logic [H_W-1:0]    h_cnt_q, h_cnt_d;
   logic [V_W-1:0]    v_cnt_q, v_cnt_d;
   logic              head_vld, pop, push, rdreq, at_sop, at_eop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   assign head_vld = (occ_q != '0) && !rst_i;
   assign pop      = head_vld && vst_ready_i;
   // Returning data is dropped on a flush cycle: it belongs to the aborted stream.
   assign push     = pipe_q[RD_LAT-1] && !flush_i;

   always_comb begin
      in_flight = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         in_flight = in_flight + CNT_W'(pipe_q[i]);
      end
   end

   // A slot freed by this cycle's pop can be re-credited immediately for full rate.
   assign rdreq = !rst_i && !flush_i && !fifo_empty_i &&
                  ((occ_q - CNT_W'(pop) + in_flight) < CNT_FULL);

   always_comb begin
      pipe_d    = '0;
      pipe_d[0] = rdreq;
      for (int i = 1; i < RD_LAT; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   assign occ_d    = occ_q + CNT_W'(push) - CNT_W'(pop);
   assign rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
   assign wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;

   always_comb begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      if (pop) begin
         if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + V_W'(1);
         end else begin
            h_cnt_d = h_cnt_q + H_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         occ_q    <= '0;
         pipe_q   <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         h_cnt_q  <= '0;
         v_cnt_q  <= '0;
      end else begin
         occ_q    <= occ_d;
         pipe_q   <= pipe_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         h_cnt_q  <= h_cnt_d;
         v_cnt_q  <= v_cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         buf_q[wr_ptr_q] <= fifo_q_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         assert (!(push && !pop && (occ_q == CNT_FULL)));
         assert (!(pop && (occ_q == '0)));
      end
   end

   assign at_sop = (h_cnt_q == '0) && (v_cnt_q == '0);
   assign at_eop = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);

   assign fifo_rdreq_o = rdreq;
   assign fifo_aclr_o  = rst_i || flush_i;
   assign vst_valid_o  = head_vld;
   assign vst_data_o   = head_vld ? buf_q[rd_ptr_q] : '0;
   assign vst_sop_o    = head_vld && at_sop;
   assign vst_eop_o    = head_vld && at_eop;
   assign frame_done_o = pop && at_eop;

endmodule

// File: tb/tb_osd_stream_reader.sv
// Bench for osd_stream_reader: three instances (RD_LAT 1..3, 4x2 frames) share one
// stimulus stream; each has its own FIFO model and scoreboard checked by a monitor.
module tb_osd_stream_reader;

   localparam int NL = 3;
   localparam int FR = 8;
   localparam int DEPTH = 1024;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1;
   logic flush = 1'b0;
   logic ready = 1'b0;
   logic gate = 1'b0;
   bit   rdy_rand = 1'b0;
   bit   gate_tog = 1'b0;

   logic [NL-1:0] fifo_empty, rdreq, aclr, valid, sop, eop, fdone;
   logic [23:0]   fifo_q [NL];
   logic [23:0]   vdata [NL];

   // upstream FIFO model and its read-latency delay line
   logic [23:0] mem [NL][DEPTH];
   logic [23:0] dl [NL][3];
   int          wp [NL];
   int          rp [NL];

   // scoreboard: expected pixels with their frame markers
   logic [23:0] exp_d [NL][DEPTH];
   logic        exp_s [NL][DEPTH];
   logic        exp_e [NL][DEPTH];
   int          eh [NL];
   int          et [NL];
   int          got [NL];
   int          outst [NL];
   int          g0 [NL];

   logic [NL-1:0] rdreq_s = '0;
   logic [NL-1:0] aclr_s = '0;
   logic [NL-1:0] hold = '0;
   logic [23:0]   held [NL];
   logic          flush_prev = 1'b0;
   int            pos = 0;
   int            checks = 0;
   int            errors = 0;
   int            idx;

   for (genvar g = 0; g < NL; g++) begin : g_lane
      assign fifo_empty[g] = gate | (wp[g] == rp[g]);
      assign fifo_q[g]     = dl[g][g];
      osd_stream_reader #(
         .DATA_W(24), .RD_LAT(g + 1), .H_ACTIVE(4), .V_ACTIVE(2)
      ) u_dut (
         .clk_i(clk), .rst_i(rst), .flush_i(flush),
         .fifo_empty_i(fifo_empty[g]), .fifo_q_i(fifo_q[g]),
         .fifo_rdreq_o(rdreq[g]), .fifo_aclr_o(aclr[g]),
         .vst_ready_i(ready), .vst_valid_o(valid[g]), .vst_data_o(vdata[g]),
         .vst_sop_o(sop[g]), .vst_eop_o(eop[g]), .frame_done_o(fdone[g])
      );
   end

   function automatic void chk(input string name, input int l,
                               input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s lane%0d: got %0h, expected %0h", name, l, act, expv);
      end
   endfunction

   // Monitor: samples mid-cycle, compares against the scoreboard head.
   always @(negedge clk) begin
      for (int l = 0; l < NL; l++) begin
         chk("aclr", l, 32'(aclr[l]), 32'(rst || flush));
         if (rst) begin
            chk("rst_ctrl", l, 32'({rdreq[l], valid[l], sop[l], eop[l], fdone[l]}), 32'd0);
            chk("rst_data", l, 32'(vdata[l]), 32'd0);
         end else begin
            if (rdreq[l]) chk("rdreq_when_empty", l, 32'(fifo_empty[l]), 32'd0);
            if (flush) chk("rdreq_in_flush", l, 32'(rdreq[l]), 32'd0);
            if (flush_prev) chk("valid_after_flush", l, 32'(valid[l]), 32'd0);
            if (hold[l]) begin
               chk("hold_valid", l, 32'(valid[l]), 32'd1);
               chk("hold_data", l, 32'(vdata[l]), 32'(held[l]));
            end
            if (valid[l]) begin
               if (eh[l] == et[l]) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_beat lane%0d: got data %0h, expected no beat", l, vdata[l]);
               end else begin
                  idx = eh[l] % DEPTH;
                  chk("sop", l, 32'(sop[l]), 32'(exp_s[l][idx]));
                  chk("eop", l, 32'(eop[l]), 32'(exp_e[l][idx]));
                  if (ready) begin
                     chk("data", l, 32'(vdata[l]), 32'(exp_d[l][idx]));
                     chk("frame_done", l, 32'(fdone[l]), 32'(exp_e[l][idx]));
                     eh[l]++;
                     got[l]++;
                  end else begin
                     chk("frame_done_stalled", l, 32'(fdone[l]), 32'd0);
                  end
               end
            end else begin
               chk("flags_idle", l, 32'({sop[l], eop[l], fdone[l]}), 32'd0);
            end
            outst[l] = outst[l] + int'(rdreq[l]) - int'(valid[l] && ready);
            chk("outstanding_le_bufd", l, 32'(outst[l] <= l + 2), 32'd1);
         end
         if (rst || flush) begin
            eh[l]    = et[l];
            outst[l] = 0;
            hold[l]  = 1'b0;
         end else begin
            hold[l] = valid[l] && !ready;
         end
         held[l]    = vdata[l];
         rdreq_s[l] = rdreq[l];
         aclr_s[l]  = aclr[l];
      end
      flush_prev = flush && !rst;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
      for (int l = 0; l < NL; l++) begin
         dl[l][2] = dl[l][1];
         dl[l][1] = dl[l][0];
         dl[l][0] = 24'($urandom);
         if (aclr_s[l]) begin
            rp[l] = wp[l];
         end else if (rdreq_s[l]) begin
            if (rp[l] == wp[l]) begin
               checks++;
               errors++;
               $display("FAIL fifo_underflow lane%0d: got read on empty FIFO, expected none", l);
            end else begin
               dl[l][0] = mem[l][rp[l] % DEPTH];
               rp[l]++;
            end
         end
      end
      if (rdy_rand) ready = 1'($urandom);
      gate = gate_tog ? ~gate : 1'b0;
   endtask

   task automatic wr_pix();
      logic [23:0] d;
      d = 24'($urandom);
      for (int l = 0; l < NL; l++) begin
         mem[l][wp[l] % DEPTH] = d;
         wp[l]++;
         exp_d[l][et[l] % DEPTH] = d;
         exp_s[l][et[l] % DEPTH] = (pos % FR) == 0;
         exp_e[l][et[l] % DEPTH] = (pos % FR) == FR - 1;
         et[l]++;
      end
      pos++;
   endtask

   task automatic wait_got(input int l, input int n, input int budget);
      int k;
      k = 0;
      while (got[l] < n && k < budget) begin
         cyc();
         k++;
      end
      chk("wait_beats", l, 32'(got[l] >= n), 32'd1);
   endtask

   task automatic drain(input int budget);
      int  k;
      bit  busy;
      k    = 0;
      busy = 1'b1;
      while (busy && k < budget) begin
         cyc();
         k++;
         busy = 1'b0;
         for (int l = 0; l < NL; l++) begin
            if (eh[l] != et[l] || rp[l] != wp[l]) busy = 1'b1;
         end
      end
      for (int l = 0; l < NL; l++) begin
         chk("drained", l, 32'(eh[l] == et[l] && rp[l] == wp[l]), 32'd1);
      end
   endtask

   task automatic tput(input int n);
      rdy_rand = 1'b0;
      gate_tog = 1'b0;
      ready    = 1'b1;
      for (int l = 0; l < NL; l++) g0[l] = got[l];
      for (int i = 0; i < n; i++) wr_pix();
      for (int k = 1; k <= n + NL + 1; k++) begin
         cyc();
         for (int l = 0; l < NL; l++) begin
            if (k == n + l + 1) chk("tput_first_edge", l, 32'(got[l] - g0[l]), 32'(n - 1));
            if (k == n + l + 2) chk("tput_all_beats", l, 32'(got[l] - g0[l]), 32'(n));
         end
      end
   endtask

   initial begin
      for (int l = 0; l < NL; l++) begin
         wp[l] = 0; rp[l] = 0; eh[l] = 0; et[l] = 0; got[l] = 0; outst[l] = 0;
         held[l] = '0;
         for (int k = 0; k < 3; k++) dl[l][k] = '0;
      end
      rst = 1'b1;
      repeat (3) cyc();
      rst = 1'b0;
      pos = 0;

      // one full frame at full rate, then a longer burst
      tput(FR);
      tput(20);

      // backpressure mid-stream
      ready = 1'b1;
      for (int i = 0; i < 16; i++) wr_pix();
      repeat (4) cyc();
      ready = 1'b0;
      repeat (10) cyc();
      ready = 1'b1;
      drain(300);

      // bubbles: empty flag toggling, random ready
      gate_tog = 1'b1;
      rdy_rand = 1'b1;
      for (int i = 0, n = 0; i < 60; i++) begin
         if (n < 16 && $urandom_range(1) == 1) begin
            wr_pix();
            n++;
         end
         cyc();
      end
      drain(500);
      gate_tog = 1'b0;
      rdy_rand = 1'b0;

      // flush after pixel 3 of a frame
      ready = 1'b1;
      g0[0] = got[0];
      for (int i = 0; i < 12; i++) wr_pix();
      wait_got(0, g0[0] + 3, 50);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      pos = 0;
      for (int i = 0; i < FR; i++) wr_pix();
      drain(300);

      // reset mid-frame after pixel 5
      g0[0] = got[0];
      for (int i = 0; i < 12; i++) wr_pix();
      wait_got(0, g0[0] + 5, 50);
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      pos = 0;
      for (int i = 0; i < FR; i++) wr_pix();
      drain(300);

      // random traffic with occasional flushes
      rdy_rand = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(3) != 0) wr_pix();
         if ($urandom_range(79) == 0) begin
            flush = 1'b1;
            cyc();
            flush = 1'b0;
            pos = 0;
         end else begin
            cyc();
         end
      end
      drain(3000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/osd_stream_reader.md
OSD_STREAM_READER -- requirements
Module: osd_stream_reader

Interface
REQ-001 Parameter DATA_W, default 24, pixel data width in bits.
REQ-002 Parameter RD_LAT, default 1, FIFO read latency in cycles (rdreq to valid q); legal values 1..3.
REQ-003 Parameter H_ACTIVE, default 1920, pixels per line.
REQ-004 Parameter V_ACTIVE, default 1080, lines per frame.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 flush  input  1  synchronous abort: discard buffered/in-flight data, restart frame.
REQ-008 fifo_empty  input  1  upstream FIFO empty flag.
REQ-009 fifo_q  input  DATA_W  upstream FIFO read data, valid RD_LAT cycles after an accepted fifo_rdreq.
REQ-010 fifo_rdreq  output  1  FIFO read request.
REQ-011 fifo_aclr  output  1  FIFO clear request.
REQ-012 vst_ready  input  1  downstream ready.
REQ-013 vst_valid  output  1  downstream valid.
REQ-014 vst_data  output  DATA_W  downstream pixel.
REQ-015 vst_sop  output  1  first pixel of frame, qualified by vst_valid.
REQ-016 vst_eop  output  1  last pixel of frame, qualified by vst_valid.
REQ-017 frame_done  output  1  one-cycle pulse on the cycle the eop beat is accepted.

Function
REQ-018 Internal output buffer SHALL hold BUF_D = RD_LAT+1 entries (FIFO order).
REQ-019 Credit rule: fifo_rdreq SHALL be 1 iff !fifo_empty && !flush && (occupancy + in_flight) < BUF_D, where occupancy counts entries popped this cycle as freed.
REQ-020 Each fifo_rdreq SHALL be tracked in an RD_LAT-deep shift pipeline; fifo_q SHALL be written into the buffer exactly RD_LAT cycles later.
REQ-021 vst_valid SHALL be 1 iff buffer occupancy > 0; vst_data SHALL be the head entry.
REQ-022 Beat accepted when vst_valid && vst_ready; head popped same cycle; vst_valid/vst_data SHALL hold stable while vst_valid && !vst_ready.
REQ-023 Simultaneous push and pop SHALL leave occupancy unchanged; buffer SHALL never overflow or underflow (assertion).
REQ-024 Sustained throughput SHALL be 1 beat/cycle when FIFO non-empty and vst_ready held high.
REQ-025 Counters h_cnt (0..H_ACTIVE-1) and v_cnt (0..V_ACTIVE-1) SHALL advance only on accepted beats; h_cnt wraps to 0 and increments v_cnt; at h_cnt=H_ACTIVE-1, v_cnt=V_ACTIVE-1 both wrap to 0.
REQ-026 vst_sop SHALL be 1 when h_cnt=0 && v_cnt=0; vst_eop SHALL be 1 when h_cnt=H_ACTIVE-1 && v_cnt=V_ACTIVE-1; both 0 when vst_valid=0.
REQ-027 Counter widths SHALL be clog2 of the respective parameter (min 1).
REQ-028 flush SHALL, on the next edge: clear occupancy, in-flight pipeline, h_cnt, v_cnt; vst_valid=0 the following cycle; fifo_aclr=1 during the flush cycle.
REQ-029 Data returning from reads issued before flush SHALL be discarded, never written to the buffer.
REQ-030 flush concurrent with an accepted beat: beat counts as delivered, frame_done still pulses if that beat was eop, counters then reset.
REQ-031 fifo_empty rising while reads are in flight SHALL NOT cancel those reads.

Reset
REQ-032 While rst=1: fifo_aclr=1, fifo_rdreq=0, vst_valid=0, vst_sop=0, vst_eop=0, frame_done=0, vst_data=0.
REQ-033 On the first cycle after rst deasserts: occupancy=0, in-flight=0, h_cnt=0, v_cnt=0; rst mid-frame SHALL discard the partial frame with no eop.
REQ-034 fifo_aclr SHALL equal rst || flush, combinationally.

Verification
REQ-035 Streaming: H_ACTIVE=4, V_ACTIVE=2, RD_LAT=2, 8 pixels in FIFO, vst_ready=1 -> 8 consecutive beats after 2-cycle latency, sop on beat 0, eop+frame_done on beat 7.
REQ-036 Backpressure: vst_ready=0 for 10 cycles mid-stream -> at most BUF_D reads outstanding, vst_data stable, no pixel lost/duplicated, order preserved.
REQ-037 Bubbles: fifo_empty toggles every cycle, vst_ready random -> output sequence equals input sequence, sop/eop positions correct across two frames.
REQ-038 Flush: flush at pixel 3 with 2 reads in flight -> fifo_aclr=1 one cycle, vst_valid=0 next cycle, in-flight data dropped, next accepted beat has sop=1.
REQ-039 Reset mid-frame: rst for 2 cycles at pixel 5 -> all outputs 0 during rst, next frame begins with sop, no eop from aborted frame.
REQ-040 RD_LAT sweep 1..3 with random ready: throughput 1 beat/cycle when ready=1 and FIFO non-empty; no buffer overflow assertion fires.
